// File: rtl/modexp_stream_ctrl.sv
// Byte-stream front end for the square-and-multiply modular exponentiation core.
// Assembles m, e, n (MSB first) from the inbound stream, pulses the core start,
// waits for completion, then streams the captured result out MSB first.
// Optional build macro MODEXP_TIMEOUT_EN: bounds the WAIT state to TIMEOUT_CYCLES
// cycles, after which err pulses and the block returns to LOAD without a result.
module modexp_stream_ctrl #(
   parameter int BUS_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           s_data,
   input  logic                 s_valid,
   input  logic                 s_last,
   output logic                 s_ready,
   output logic [7:0]           m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last,
   output logic [BUS_WIDTH-1:0] core_m,
   output logic [BUS_WIDTH-1:0] core_e,
   output logic [BUS_WIDTH-1:0] core_n,
   output logic                 core_ready,
   input  logic [BUS_WIDTH-1:0] core_result,
   input  logic                 core_valid,
   output logic                 busy,
   output logic                 err
);

   localparam int BYTES = BUS_WIDTH / 8;
   localparam int KW    = $clog2(3 * BYTES);
   localparam int OW    = (BYTES > 1) ? $clog2(BYTES) : 1;

   localparam logic [KW-1:0] K_E    = KW'(BYTES);
   localparam logic [KW-1:0] K_N    = KW'(2 * BYTES);
   localparam logic [KW-1:0] K_LAST = KW'(3 * BYTES - 1);
   localparam logic [OW-1:0] O_LAST = OW'(BYTES - 1);

   // Reject configurations the byte framing cannot represent
   if ((BUS_WIDTH % 8) != 0 || BUS_WIDTH < 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("modexp_stream_ctrl: BUS_WIDTH must be a positive multiple of 8 and TIMEOUT_CYCLES >= 1");
   end

   typedef enum logic [1:0] {LOAD, START, WAIT, SEND} state_t;

   state_t                state, state_nxt;
   logic [KW-1:0]         k;
   logic [OW-1:0]         out_cnt;
   logic [BUS_WIDTH-1:0]  result_reg;
   logic                  s_xfer, m_xfer;
   logic                  frame_done, frame_abort, send_done;
   logic                  timeout_hit;

   // Shift one byte into the LSB end of an operand register; works for BUS_WIDTH == 8
   function automatic logic [BUS_WIDTH-1:0] shift_in(input logic [BUS_WIDTH-1:0] r,
                                                     input logic [7:0]           b);
      return BUS_WIDTH'({r, b});
   endfunction

   assign s_xfer      = s_valid && (state == LOAD);
   assign m_xfer      = m_ready && (state == SEND);
   assign frame_done  = s_xfer && (k == K_LAST);
   assign frame_abort = s_xfer && s_last && (k != K_LAST);
   assign send_done   = m_xfer && (out_cnt == O_LAST);

`ifdef MODEXP_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] wait_cnt;

   // WAIT-cycle counter; cleared in START so it is zero on the first WAIT cycle
   always_ff @(posedge clk) begin
      if (reset)
         wait_cnt <= '0;
      else if (state == START)
         wait_cnt <= '0;
      else if (state == WAIT)
         wait_cnt <= wait_cnt + 1'b1;
   end

   // A completion arriving in the final allowed cycle still wins over the timeout
   assign timeout_hit = (state == WAIT) && !core_valid && (wait_cnt == T_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         state <= LOAD;
      else
         state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:  if (frame_done) state_nxt = START;
         START: state_nxt = WAIT;
         WAIT:  begin
            if (core_valid)
               state_nxt = SEND;
            else if (timeout_hit)
               state_nxt = LOAD;
         end
         SEND:  if (send_done) state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   // Outputs decoded from state; m_data is always the top byte of the result register
   always_comb begin
      s_ready    = (state == LOAD);
      busy       = (state != LOAD);
      core_ready = (state == START);
      m_valid    = (state == SEND);
      m_last     = (state == SEND) && (out_cnt == O_LAST);
      m_data     = result_reg[BUS_WIDTH-1 -: 8];
   end

   // Operand assembly, result capture/shift-out and the registered error pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         k          <= '0;
         out_cnt    <= '0;
         core_m     <= '0;
         core_e     <= '0;
         core_n     <= '0;
         result_reg <= '0;
         err        <= 1'b0;
      end else begin
         err <= frame_abort || timeout_hit;
         if (s_xfer) begin
            k <= (frame_done || frame_abort) ? '0 : k + 1'b1;
            if (k < K_E)
               core_m <= shift_in(core_m, s_data);
            else if (k < K_N)
               core_e <= shift_in(core_e, s_data);
            else
               core_n <= shift_in(core_n, s_data);
         end
         if ((state == WAIT) && core_valid) begin
            result_reg <= core_result;
            out_cnt    <= '0;
         end else if (m_xfer) begin
            result_reg <= result_reg << 8;
            out_cnt    <= out_cnt + 1'b1;
         end
      end
   end

endmodule
